// File: rtl/mips32_pkg.sv
// Shared types and default widths for the MIPS32 memory arbiter and pipeline core.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package mips32_pkg;

  localparam int DEF_ADDR_W = 10;
  localparam int DEF_DATA_W = 32;

  // Latency counter width; holds the largest legal memory latency (4).
  localparam int LAT_W = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } owner_e;

  // Bits needed to count 0..lim; at least one bit so a zero limit still elaborates.
  function automatic int cnt_width(input int lim);
    return (lim < 1) ? 1 : $clog2(lim + 1);
  endfunction

endpackage

// File: rtl/mips32_arb_pick.sv
// Fetch/data priority select with a starvation override for fetch.
// Latency: purely combinational.
// Backpressure: none; callers only sample the grants when the arbiter is idle.
module mips32_arb_pick #(
  parameter int STARVE_LIM = 3,
  parameter int CNT_W      = 2
) (
  input  logic             if_req,
  input  logic             dm_req,
  input  logic [CNT_W-1:0] starve_cnt,
  output logic             grant_if,
  output logic             grant_dm
);

  localparam logic [CNT_W-1:0] LIM = CNT_W'(STARVE_LIM);

  logic if_starved;

  // Data wins unless fetch has already sat through STARVE_LIM consecutive data grants.
  always_comb begin
    if_starved = if_req && (starve_cnt == LIM);
    grant_dm   = dm_req && !if_starved;
    grant_if   = if_req && !grant_dm;
  end

endmodule

// File: rtl/mips32_mem_arbiter.sv
// Single-port memory arbiter between the IF fetch port and the MEM load/store port.
// Latency: gnt one cycle after req is seen in IDLE, rvalid MEM_LAT+1 cycles after gnt.
// Backpressure: one access in flight; requesters hold req until gnt, req ignored while busy.
module mips32_mem_arbiter
  import mips32_pkg::*;
#(
  parameter int ADDR_W     = mips32_pkg::DEF_ADDR_W,
  parameter int DATA_W     = mips32_pkg::DEF_DATA_W,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_LIM = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_gnt,
  output logic              dm_rvalid,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int               CNT_W      = cnt_width(STARVE_LIM);
  localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIM);
  localparam logic [LAT_W-1:0] LAT_INIT   = LAT_W'(MEM_LAT);
  localparam logic [LAT_W-1:0] LAT_ONE    = LAT_W'(1);

  arb_state_e        state_q, state_d;
  owner_e            owner_q, owner_d;
  logic              we_q, we_d;
  logic [LAT_W-1:0]  lat_cnt_q, lat_cnt_d;
  logic [CNT_W-1:0]  starve_cnt_q, starve_cnt_d;
  logic              squash_q, squash_d;
  logic              if_gnt_q, if_gnt_d;
  logic              dm_gnt_q, dm_gnt_d;
  logic              if_rvalid_q, if_rvalid_d;
  logic              dm_rvalid_q, dm_rvalid_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              busy_q, busy_d;

  logic grant_if, grant_dm;
  logic squash_now;

  mips32_arb_pick #(
    .STARVE_LIM (STARVE_LIM),
    .CNT_W      (CNT_W)
  ) u_pick (
    .if_req     (if_req),
    .dm_req     (dm_req),
    .starve_cnt (starve_cnt_q),
    .grant_if   (grant_if),
    .grant_dm   (grant_dm)
  );

  // Next-state, output and datapath computation for the single-transaction FSM.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    we_d         = we_q;
    lat_cnt_d    = lat_cnt_q;
    starve_cnt_d = starve_cnt_q;
    squash_d     = squash_q;
    if_rdata_d   = if_rdata_q;
    dm_rdata_d   = dm_rdata_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    if_gnt_d     = 1'b0;
    dm_gnt_d     = 1'b0;
    if_rvalid_d  = 1'b0;
    dm_rvalid_d  = 1'b0;
    mem_en_d     = 1'b0;
    mem_we_d     = 1'b0;

    // A flush seen while a fetch owns the port kills its response, including this cycle's capture.
    squash_now = squash_q || (if_flush && (owner_q == OWN_IF) && (state_q != IDLE));

    case (state_q)
      IDLE: begin
        squash_d = 1'b0;
        if (grant_dm) begin
          state_d     = ISSUE;
          owner_d     = OWN_DM;
          we_d        = dm_we;
          mem_en_d    = 1'b1;
          mem_we_d    = dm_we;
          mem_addr_d  = dm_addr;
          mem_wdata_d = dm_wdata;
          dm_gnt_d    = 1'b1;
          if (!if_req) begin
            starve_cnt_d = '0;
          end else if (starve_cnt_q != STARVE_MAX) begin
            starve_cnt_d = starve_cnt_q + CNT_W'(1);
          end
        end else if (grant_if) begin
          state_d      = ISSUE;
          owner_d      = OWN_IF;
          we_d         = 1'b0;
          mem_en_d     = 1'b1;
          mem_addr_d   = if_addr;
          mem_wdata_d  = '0;
          if_gnt_d     = 1'b1;
          starve_cnt_d = '0;
          squash_d     = if_flush;
        end
      end
      ISSUE: begin
        state_d   = WAIT;
        lat_cnt_d = LAT_INIT;
        squash_d  = squash_now;
      end
      WAIT: begin
        lat_cnt_d = lat_cnt_q - LAT_ONE;
        squash_d  = squash_now;
        if (lat_cnt_q == LAT_ONE) begin
          state_d = RESP;
          if (owner_q == OWN_DM) begin
            dm_rvalid_d = 1'b1;
            if (!we_q) begin
              dm_rdata_d = mem_rdata;
            end
          end else if (!squash_now) begin
            if_rvalid_d = 1'b1;
            if_rdata_d  = mem_rdata;
          end
        end
      end
      RESP: begin
        state_d  = IDLE;
        squash_d = 1'b0;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // All state and every output are registered here; reset drops any in-flight access.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      owner_q      <= OWN_IF;
      we_q         <= 1'b0;
      lat_cnt_q    <= '0;
      starve_cnt_q <= '0;
      squash_q     <= 1'b0;
      if_gnt_q     <= 1'b0;
      dm_gnt_q     <= 1'b0;
      if_rvalid_q  <= 1'b0;
      dm_rvalid_q  <= 1'b0;
      if_rdata_q   <= '0;
      dm_rdata_q   <= '0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      we_q         <= we_d;
      lat_cnt_q    <= lat_cnt_d;
      starve_cnt_q <= starve_cnt_d;
      squash_q     <= squash_d;
      if_gnt_q     <= if_gnt_d;
      dm_gnt_q     <= dm_gnt_d;
      if_rvalid_q  <= if_rvalid_d;
      dm_rvalid_q  <= dm_rvalid_d;
      if_rdata_q   <= if_rdata_d;
      dm_rdata_q   <= dm_rdata_d;
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      busy_q       <= busy_d;
    end
  end

  assign if_gnt    = if_gnt_q;
  assign dm_gnt    = dm_gnt_q;
  assign if_rvalid = if_rvalid_q;
  assign dm_rvalid = dm_rvalid_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_mips32_mem_arbiter.sv
// Directed scoreboard bench for mips32_mem_arbiter with a latency-accurate memory model.
// Latency: memory model returns read data exactly LAT cycles after mem_en.
// Backpressure: requests held until gnt, dropped in the grant cycle.
module tb_mips32_mem_arbiter;

  localparam int          LAT = 3;
  localparam int          AW  = 10;
  localparam int          DW  = 32;
  localparam logic [31:0] BAD = 32'hBADBAD00;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req, if_flush, if_gnt, if_rvalid;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          dm_req, dm_we, dm_gnt, dm_rvalid;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata, dm_rdata;
  logic          mem_en, mem_we, busy;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  mips32_mem_arbiter #(
    .ADDR_W     (AW),
    .DATA_W     (DW),
    .MEM_LAT    (LAT),
    .STARVE_LIM (3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_flush  (if_flush),
    .if_gnt    (if_gnt),
    .if_rvalid (if_rvalid),
    .if_rdata  (if_rdata),
    .dm_req    (dm_req),
    .dm_we     (dm_we),
    .dm_addr   (dm_addr),
    .dm_wdata  (dm_wdata),
    .dm_gnt    (dm_gnt),
    .dm_rvalid (dm_rvalid),
    .dm_rdata  (dm_rdata),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .busy      (busy)
  );

  // Memory model: contents loaded under reset, read data valid only in the LAT-th cycle after mem_en.
  logic [DW-1:0]  mem    [0:(1<<AW)-1];
  logic [DW-1:0]  rd_dat [LAT];
  logic [LAT-1:0] rd_vld;

  always @(posedge clk) begin
    if (rst) begin
      mem[5]  <= 32'h2881000A;
      mem[7]  <= 32'h00000055;
      mem[9]  <= 32'h00000000;
      mem[11] <= 32'h11111111;
      mem[32] <= 32'hA5A50020;
      mem[40] <= 32'h00000028;
      rd_vld  <= '0;
    end else begin
      for (int k = LAT - 1; k > 0; k--) begin
        rd_vld[k] <= rd_vld[k-1];
        rd_dat[k] <= rd_dat[k-1];
      end
      rd_vld[0] <= mem_en && !mem_we;
      rd_dat[0] <= mem[mem_addr];
      if (mem_en && mem_we) mem[mem_addr] <= mem_wdata;
    end
  end

  assign mem_rdata = rd_vld[LAT-1] ? rd_dat[LAT-1] : BAD;

  int errors = 0;
  int checks = 0;
  int we_cycles = 0;

  logic [1:0]  gnt_q [$];
  logic [31:0] if_q  [$];
  logic [31:0] dm_q  [$];

  localparam logic [1:0] G_IF = 2'b10;
  localparam logic [1:0] G_DM = 2'b01;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Scoreboard: grants and responses are popped and compared as the DUT produces them.
  always @(negedge clk) begin
    if (mem_we === 1'b1) we_cycles++;
    if (if_gnt === 1'b1 || dm_gnt === 1'b1) begin
      if (gnt_q.size() == 0) chk("gnt_unexpected", {30'd0, if_gnt, dm_gnt}, 32'd0);
      else                   chk("gnt_order", {30'd0, if_gnt, dm_gnt}, {30'd0, gnt_q.pop_front()});
    end
    if (if_rvalid === 1'b1) begin
      if (if_q.size() == 0) chk1("if_rvalid_unexpected", if_rvalid, 1'b0);
      else                  chk("if_rdata", if_rdata, if_q.pop_front());
    end
    if (dm_rvalid === 1'b1) begin
      if (dm_q.size() == 0) chk1("dm_rvalid_unexpected", dm_rvalid, 1'b0);
      else                  chk("dm_rdata", dm_rdata, dm_q.pop_front());
    end
  end

  // sel: 0 = dm_gnt, 1 = if_gnt, 2 = either.
  task automatic wait_gnt(input int sel, input string tag);
    int n = 0;
    logic hit = 1'b0;
    while (!hit && n < 40) begin
      @(negedge clk);
      n++;
      hit = (sel == 0) ? (dm_gnt === 1'b1) :
            (sel == 1) ? (if_gnt === 1'b1) : (dm_gnt === 1'b1 || if_gnt === 1'b1);
    end
    chk1({tag, "_gnt_seen"}, hit, 1'b1);
  endtask

  task automatic drain(input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((busy === 1'b1 || gnt_q.size() != 0 || if_q.size() != 0 || dm_q.size() != 0) && n < 100);
    chk1({tag, "_drained"}, n < 100, 1'b1);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ctl"}, {25'd0, if_gnt, if_rvalid, dm_gnt, dm_rvalid, mem_en, mem_we, busy}, 32'd0);
    chk({tag, "_if_rdata"}, if_rdata, 32'd0);
    chk({tag, "_dm_rdata"}, dm_rdata, 32'd0);
    chk({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int we_base;
    rst = 1'b1;
    if_req = 1'b0; if_addr = '0; if_flush = 1'b0;
    dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    // Lone fetch with exact cycle timing.
    if_addr = 10'd5; if_req = 1'b1;
    gnt_q.push_back(G_IF); if_q.push_back(32'h2881000A);
    @(negedge clk);
    chk1("lone_if_gnt", if_gnt, 1'b1);
    chk1("lone_mem_en", mem_en, 1'b1);
    chk1("lone_mem_we", mem_we, 1'b0);
    chk("lone_mem_addr", 32'(mem_addr), 32'd5);
    chk1("lone_busy", busy, 1'b1);
    if_req = 1'b0;
    repeat (LAT + 1) @(negedge clk);
    chk1("lone_if_rvalid", if_rvalid, 1'b1);
    chk("lone_if_rdata", if_rdata, 32'h2881000A);
    @(negedge clk);
    chk1("lone_busy_low", busy, 1'b0);
    chk1("lone_rvalid_pulse", if_rvalid, 1'b0);

    // Simultaneous requests: data first, fetch at the following arbitration.
    if_addr = 10'd11; if_req = 1'b1;
    dm_addr = 10'd7; dm_we = 1'b0; dm_req = 1'b1;
    gnt_q.push_back(G_DM); gnt_q.push_back(G_IF);
    dm_q.push_back(32'h00000055); if_q.push_back(32'h11111111);
    wait_gnt(0, "both_dm");
    dm_req = 1'b0;
    wait_gnt(1, "both_if");
    if_req = 1'b0;
    drain("both");

    // Starvation guard: dm, dm, dm, if, dm with data held continuously.
    dm_addr = 10'd32; dm_req = 1'b1;
    if_addr = 10'd40; if_req = 1'b1;
    gnt_q.push_back(G_DM); gnt_q.push_back(G_DM); gnt_q.push_back(G_DM);
    gnt_q.push_back(G_IF); gnt_q.push_back(G_DM);
    for (int k = 0; k < 4; k++) dm_q.push_back(32'hA5A50020);
    if_q.push_back(32'h00000028);
    for (int g = 0; g < 5; g++) begin
      wait_gnt(2, "starve");
      if (if_gnt === 1'b1) begin
        if_req = 1'b0;
        chk("starve_cnt_clr", 32'(dut.starve_cnt_q), 32'd0);
      end
      if (g == 4) dm_req = 1'b0;
    end
    drain("starve");

    // Store: one-cycle write strobe, completion pulse, dm_rdata untouched; then read back.
    we_base = we_cycles;
    dm_addr = 10'd9; dm_we = 1'b1; dm_wdata = 32'hDEADBEEF; dm_req = 1'b1;
    gnt_q.push_back(G_DM); dm_q.push_back(32'hA5A50020);
    wait_gnt(0, "store");
    dm_req = 1'b0;
    chk1("store_mem_we", mem_we, 1'b1);
    chk("store_mem_addr", 32'(mem_addr), 32'd9);
    chk("store_mem_wdata", mem_wdata, 32'hDEADBEEF);
    @(negedge clk);
    chk1("store_mem_we_off", mem_we, 1'b0);
    drain("store");
    chk("store_we_cycles", 32'(we_cycles - we_base), 32'd1);
    chk("store_dm_rdata_kept", dm_rdata, 32'hA5A50020);
    dm_we = 1'b0; dm_req = 1'b1;
    gnt_q.push_back(G_DM); dm_q.push_back(32'hDEADBEEF);
    wait_gnt(0, "readback");
    dm_req = 1'b0;
    drain("readback");

    // Flush during WAIT: response squashed, busy timing unchanged.
    if_addr = 10'd5; if_req = 1'b1;
    gnt_q.push_back(G_IF);
    wait_gnt(1, "flush");
    if_req = 1'b0;
    @(negedge clk);
    if_flush = 1'b1;
    @(negedge clk);
    if_flush = 1'b0;
    repeat (LAT - 1) @(negedge clk);
    chk1("flush_busy_resp", busy, 1'b1);
    chk1("flush_no_rvalid", if_rvalid, 1'b0);
    @(negedge clk);
    chk1("flush_busy_low", busy, 1'b0);
    chk("flush_rdata_kept", if_rdata, 32'h00000028);
    if_addr = 10'd11; if_req = 1'b1;
    gnt_q.push_back(G_IF); if_q.push_back(32'h11111111);
    wait_gnt(1, "post_flush");
    if_req = 1'b0;
    drain("post_flush");

    // Flush in the grant cycle squashes; flush never affects a data access.
    if_addr = 10'd5; if_req = 1'b1; if_flush = 1'b1;
    gnt_q.push_back(G_IF);
    @(negedge clk);
    if_flush = 1'b0; if_req = 1'b0;
    chk1("flush_gnt_if_gnt", if_gnt, 1'b1);
    drain("flush_gnt");
    chk("flush_gnt_rdata_kept", if_rdata, 32'h11111111);
    dm_addr = 10'd7; dm_we = 1'b0; dm_req = 1'b1; if_flush = 1'b1;
    gnt_q.push_back(G_DM); dm_q.push_back(32'h00000055);
    wait_gnt(0, "dm_flush");
    dm_req = 1'b0;
    drain("dm_flush");
    if_flush = 1'b0;

    // Reset during WAIT: everything zero next cycle, aborted access never responds.
    dm_addr = 10'd7; dm_req = 1'b1;
    gnt_q.push_back(G_DM);
    wait_gnt(0, "rst_mid");
    dm_req = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk_zero("rst_mid");
    rst = 1'b0;
    repeat (LAT + 4) @(negedge clk);
    chk1("rst_mid_idle", busy, 1'b0);
    if_addr = 10'd5; if_req = 1'b1;
    gnt_q.push_back(G_IF); if_q.push_back(32'h2881000A);
    @(negedge clk);
    chk1("rst_then_if_gnt", if_gnt, 1'b1);
    if_req = 1'b0;
    drain("rst_then_fetch");

    chk("end_gnt_q", 32'(gnt_q.size()), 32'd0);
    chk("end_if_q", 32'(if_q.size()), 32'd0);
    chk("end_dm_q", 32'(dm_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
